// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - shared types, mode encodings and pointer arithmetic for the data memory LSU
package data_mem_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;

  localparam logic [1:0] MODE_DIRECT  = 2'b00;
  localparam logic [1:0] MODE_POSTINC = 2'b01;
  localparam logic [1:0] MODE_PREDEC  = 2'b10;
  localparam logic [1:0] MODE_RSVD    = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } lsu_state_t;

  typedef logic [AW_DEF-1:0] ptr_t;

  // Returns {access address, updated pointer}; wraps modulo 2^AW.
  // Reserved mode passes the pointer through unchanged.
  function automatic logic [2*AW_DEF-1:0] ptr_update(input logic [1:0] mode, input ptr_t ptr);
    ptr_t addr;
    ptr_t nptr;
    addr = ptr;
    nptr = ptr;
    case (mode)
      MODE_POSTINC: nptr = ptr + ptr_t'(1);
      MODE_PREDEC: begin
        addr = ptr - ptr_t'(1);
        nptr = ptr - ptr_t'(1);
      end
      default: ;
    endcase
    return {addr, nptr};
  endfunction

endpackage

// File: rtl/data_mem_lsu.sv
// rtl/data_mem_lsu.sv - byte load/store unit driving the 256x8 synchronous data memory
import data_mem_pkg::*;

module data_mem_lsu #(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_mode,
  input  logic [AW-1:0] req_ptr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic [AW-1:0] rsp_ptr,
  output logic          rsp_err,
  output logic          en_drd,
  output logic          en_dwr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  lsu_state_t state, state_next;
  logic       we_q;
  logic       accept;
  logic [AW-1:0] addr_next;
  logic [AW-1:0] ptr_next;

  // Pointer math lives in the package and is sized by AW_DEF, so AW must match it.
  assign {addr_next, ptr_next} = ptr_update(req_mode, req_ptr);
  assign accept = (state == IDLE) && req_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Enables are decoded from state so an asynchronous reset kills them at once.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    en_drd     = 1'b0;
    en_dwr     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_next = (req_mode == MODE_RSVD) ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        en_drd     = !we_q;
        en_dwr     = we_q;
        state_next = we_q ? RESP : CAPTURE;
      end
      CAPTURE: begin
        state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q      <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
      rsp_rdata <= '0;
      rsp_ptr   <= '0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      rsp_rdata <= '0;
      if (req_mode == MODE_RSVD) begin
        rsp_err <= 1'b1;
        rsp_ptr <= req_ptr;
      end else begin
        rsp_err  <= 1'b0;
        rsp_ptr  <= ptr_next;
        mem_addr <= addr_next;
        mem_din  <= req_wdata;
        we_q     <= req_we;
      end
    end else if (state == CAPTURE) begin
      rsp_rdata <= mem_dout;
    end
  end

endmodule

// File: tb/tb_data_mem_lsu.sv
// tb/tb_data_mem_lsu.sv - directed table-driven bench for data_mem_lsu with a 256x8 memory model
module tb_data_mem_lsu;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [1:0] req_mode;
  logic [7:0] req_ptr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic [7:0] rsp_ptr;
  logic       rsp_err;
  logic       en_drd;
  logic       en_dwr;
  logic [7:0] mem_addr;
  logic [7:0] mem_din;
  logic [7:0] mem_dout;

  int checks = 0;
  int errors = 0;

  data_mem_lsu #(.AW(8), .DW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_mode  (req_mode),
    .req_ptr   (req_ptr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_ptr   (rsp_ptr),
    .rsp_err   (rsp_err),
    .en_drd    (en_drd),
    .en_dwr    (en_dwr),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem_dout = 8'h00;
  end
  always @(posedge clk) begin
    if (en_dwr) mem[mem_addr] <= mem_din;
    if (en_drd) mem_dout <= mem[mem_addr];
  end

  typedef struct {
    logic       we;
    logic [1:0] mode;
    logic [7:0] ptr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic [7:0] rptr;
    logic       err;
    int         lat;
    logic [7:0] addr;
    int         hold;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [1:0] mode, input logic [7:0] ptr,
                              input logic [7:0] wdata, input logic [7:0] rdata, input logic [7:0] rptr,
                              input logic err, input int lat, input logic [7:0] addr, input int hold);
    vec_t v;
    v.we = we; v.mode = mode; v.ptr = ptr; v.wdata = wdata; v.rdata = rdata;
    v.rptr = rptr; v.err = err; v.lat = lat; v.addr = addr; v.hold = hold;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Caller is positioned at a negedge; the request is accepted on the next posedge.
  task automatic run_vec(input int idx, input vec_t v);
    int lat;
    int nrd;
    int nwr;
    bit got;
    bit bad;
    logic [7:0] seen_addr;
    logic [7:0] seen_din;
    logic [7:0] h_rdata;
    logic [7:0] h_ptr;
    string tag;
    tag = $sformatf("v%0d", idx);
    chk({tag, "_req_ready_idle"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_we    = v.we;
    req_mode  = v.mode;
    req_ptr   = v.ptr;
    req_wdata = v.wdata;
    rsp_ready = (v.hold == 0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = ~v.we;
    req_mode  = 2'b11;
    req_ptr   = 8'h5A;
    req_wdata = 8'hC3;
    lat = 0; nrd = 0; nwr = 0; got = 1'b0;
    seen_addr = 8'h00; seen_din = 8'h00;
    for (int c = 1; c <= 20 && !got; c++) begin
      if (c > 1) @(negedge clk);
      if (en_drd) nrd++;
      if (en_dwr) nwr++;
      if (en_drd || en_dwr) begin
        seen_addr = mem_addr;
        seen_din  = mem_din;
      end
      if (c > 1) chk({tag, "_req_ready_busy"}, {31'd0, req_ready && !rsp_valid}, 32'd0);
      if (rsp_valid) begin
        got = 1'b1;
        lat = c;
      end
    end
    if (!got) begin
      chk({tag, "_rsp_timeout"}, 32'd0, 32'd1);
      rsp_ready = 1'b1;
      return;
    end
    chk({tag, "_latency"}, lat, v.lat);
    chk({tag, "_rdata"}, {24'd0, rsp_rdata}, {24'd0, v.rdata});
    chk({tag, "_ptr"}, {24'd0, rsp_ptr}, {24'd0, v.rptr});
    chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, v.err});
    chk({tag, "_rd_pulses"}, nrd, (!v.err && !v.we) ? 1 : 0);
    chk({tag, "_wr_pulses"}, nwr, (!v.err && v.we) ? 1 : 0);
    if (!v.err) chk({tag, "_addr"}, {24'd0, seen_addr}, {24'd0, v.addr});
    if (!v.err && v.we) chk({tag, "_din"}, {24'd0, seen_din}, {24'd0, v.wdata});
    if (v.hold > 0) begin
      bad = 1'b0;
      h_rdata = rsp_rdata;
      h_ptr = rsp_ptr;
      for (int h = 0; h < v.hold; h++) begin
        @(negedge clk);
        if (!rsp_valid || rsp_rdata !== h_rdata || rsp_ptr !== h_ptr || req_ready || en_drd || en_dwr)
          bad = 1'b1;
      end
      chk({tag, "_hold_stable"}, {31'd0, bad}, 32'd0);
      rsp_ready = 1'b1;
    end
    @(negedge clk);
    chk({tag, "_back_idle"}, {30'd0, rsp_valid, req_ready}, 32'd1);
  endtask

  vec_t vecs[13];
  bit   bad_rst;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_mode = 2'b00;
    req_ptr = 8'h00; req_wdata = 8'h00; rsp_ready = 1'b1;

    //          we    mode   ptr    wdata  rdata  rptr   err   lat addr   hold
    vecs[0]  = mk(1'b1, 2'd0, 8'h10, 8'hA5, 8'h00, 8'h10, 1'b0, 2, 8'h10, 0);
    vecs[1]  = mk(1'b0, 2'd0, 8'h10, 8'h00, 8'hA5, 8'h10, 1'b0, 3, 8'h10, 0);
    vecs[2]  = mk(1'b1, 2'd1, 8'hFF, 8'h3C, 8'h00, 8'h00, 1'b0, 2, 8'hFF, 0);
    vecs[3]  = mk(1'b0, 2'd0, 8'hFF, 8'h00, 8'h3C, 8'hFF, 1'b0, 3, 8'hFF, 0);
    vecs[4]  = mk(1'b1, 2'd0, 8'hFF, 8'h77, 8'h00, 8'hFF, 1'b0, 2, 8'hFF, 0);
    vecs[5]  = mk(1'b0, 2'd2, 8'h00, 8'h00, 8'h77, 8'hFF, 1'b0, 3, 8'hFF, 0);
    vecs[6]  = mk(1'b0, 2'd3, 8'h40, 8'h00, 8'h00, 8'h40, 1'b1, 1, 8'h00, 0);
    vecs[7]  = mk(1'b0, 2'd1, 8'h10, 8'h00, 8'hA5, 8'h11, 1'b0, 3, 8'h10, 0);
    vecs[8]  = mk(1'b1, 2'd3, 8'h40, 8'h55, 8'h00, 8'h40, 1'b1, 1, 8'h00, 0);
    vecs[9]  = mk(1'b0, 2'd2, 8'h11, 8'h00, 8'hA5, 8'h10, 1'b0, 3, 8'h10, 0);
    vecs[10] = mk(1'b1, 2'd2, 8'h81, 8'h99, 8'h00, 8'h80, 1'b0, 2, 8'h80, 0);
    vecs[11] = mk(1'b0, 2'd1, 8'h80, 8'h00, 8'h99, 8'h81, 1'b0, 3, 8'h80, 0);
    vecs[12] = mk(1'b0, 2'd0, 8'h10, 8'h00, 8'hA5, 8'h10, 1'b0, 3, 8'h10, 5);

    repeat (2) @(negedge clk);
    chk("rst_outputs", {8'd0, rsp_rdata, rsp_ptr, 3'd0, rsp_valid, rsp_err, en_drd, en_dwr, 1'b0},
        32'd0);
    chk("rst_mem_pins", {16'd0, mem_addr, mem_din}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

    // Reset during the ACCESS cycle of a store must abort it without touching memory.
    req_valid = 1'b1; req_we = 1'b1; req_mode = 2'd0; req_ptr = 8'h10; req_wdata = 8'hEE;
    @(posedge clk);
    #1;
    chk("midrst_en_dwr_before", {31'd0, en_dwr}, 32'd1);
    rst_n = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("midrst_outputs", {8'd0, rsp_rdata, rsp_ptr, 3'd0, rsp_valid, rsp_err, en_drd, en_dwr, 1'b0},
        32'd0);
    chk("midrst_mem_pins", {16'd0, mem_addr, mem_din}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bad_rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rsp_valid || en_drd || en_dwr || !req_ready) bad_rst = 1'b1;
    end
    chk("midrst_quiet_after", {31'd0, bad_rst}, 32'd0);
    run_vec(13, mk(1'b0, 2'd0, 8'h10, 8'h00, 8'hA5, 8'h10, 1'b0, 3, 8'h10, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
